// File: rtl/b_resp_router.sv
// b_resp_router: routes slave-side B FIFO fronts to master-side B ports.
// The upper BID bits pick the destination master. Each master runs its own
// round-robin slot. A front whose dest index has no master is dropped.

module b_resp_slot #(
  parameter int NUM_SRC  = 2,
  parameter int ID_WIDTH = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [NUM_SRC-1:0]                 cand,
  input  logic [NUM_SRC-1:0][ID_WIDTH-1:0]   src_id,
  input  logic [NUM_SRC-1:0][1:0]            src_resp,
  input  logic                               bready,
  output logic [NUM_SRC-1:0]                 grant,
  output logic                               bvalid,
  output logic [ID_WIDTH-1:0]                bid,
  output logic [1:0]                         bresp
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           state_q, state_d;
  logic [SRC_W-1:0] rr_q, sel, idx;
  logic             hit, load;

  // Round-robin search starting after the last winner, then the slot next state
  always_comb begin
    sel     = '0;
    idx     = '0;
    hit     = 1'b0;
    grant   = '0;
    load    = 1'b0;
    state_d = state_q;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = SRC_W'((int'(rr_q) + k) % NUM_SRC);
      if (!hit && cand[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
    // A full slot frees up in the same cycle it is accepted, so there is no bubble
    load = hit && ((state_q == S_EMPTY) || bready);
    if (load) grant[sel] = 1'b1;
    case (state_q)
      S_EMPTY: if (load) state_d = S_FULL;
      S_FULL:  if (bready && !load) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Slot state register
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Response payload and round-robin pointer; they change only when a response loads
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rr_q  <= SRC_W'(NUM_SRC - 1);
      bid   <= '0;
      bresp <= '0;
    end else if (load) begin
      rr_q  <= sel;
      bid   <= src_id[sel];
      bresp <= src_resp[sel];
    end
  end

  assign bvalid = (state_q == S_FULL);
endmodule

module b_resp_router #(
  parameter  int NUM_SRC    = 2,
  parameter  int NUM_DST    = 2,
  parameter  int ID_WIDTH   = 4,
  localparam int MSEL_WIDTH = $clog2(NUM_DST),
  localparam int SID_WIDTH  = ID_WIDTH + MSEL_WIDTH
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [NUM_SRC-1:0]             src_empty,
  input  logic [NUM_SRC*SID_WIDTH-1:0]   src_BID,
  input  logic [NUM_SRC*2-1:0]           src_BRESP,
  output logic [NUM_SRC-1:0]             src_pop,
  output logic [NUM_DST-1:0]             BVALID,
  input  logic [NUM_DST-1:0]             BREADY,
  output logic [NUM_DST*ID_WIDTH-1:0]    BID,
  output logic [NUM_DST*2-1:0]           BRESP,
  output logic                           drop_err
);
  logic [NUM_SRC-1:0][MSEL_WIDTH-1:0] dsel;
  logic [NUM_SRC-1:0][ID_WIDTH-1:0]   src_id;
  logic [NUM_SRC-1:0][1:0]            src_resp;
  logic [NUM_SRC-1:0]                 bad, drop_oh, pop_any;
  logic [NUM_DST-1:0][NUM_SRC-1:0]    cand, gnt;
  logic                               dropped;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign dsel[i]     = src_BID[i*SID_WIDTH+ID_WIDTH +: MSEL_WIDTH];
    assign src_id[i]   = src_BID[i*SID_WIDTH +: ID_WIDTH];
    assign src_resp[i] = src_BRESP[i*2 +: 2];
    // Only reachable when NUM_DST is not a power of two
    assign bad[i]      = !src_empty[i] && (int'(dsel[i]) >= NUM_DST);
  end

  for (genvar d = 0; d < NUM_DST; d++) begin : g_dst
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cand
      assign cand[d][i] = !src_empty[i] && (dsel[i] == MSEL_WIDTH'(d));
    end

    b_resp_slot #(.NUM_SRC(NUM_SRC), .ID_WIDTH(ID_WIDTH)) u_slot (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .cand     (cand[d]),
      .src_id   (src_id),
      .src_resp (src_resp),
      .bready   (BREADY[d]),
      .grant    (gnt[d]),
      .bvalid   (BVALID[d]),
      .bid      (BID[d*ID_WIDTH +: ID_WIDTH]),
      .bresp    (BRESP[d*2 +: 2])
    );
  end

  // Drop the lowest-index front that has no master, one per cycle
  always_comb begin
    drop_oh = '0;
    dropped = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!dropped && bad[i]) begin
        drop_oh[i] = 1'b1;
        dropped    = 1'b1;
      end
    end
  end

  // Each front targets a single master, so OR-ing the per-master grants never double-pops
  always_comb begin
    pop_any = '0;
    for (int d = 0; d < NUM_DST; d++) pop_any = pop_any | gnt[d];
  end

  assign src_pop  = ARESET ? '0 : (pop_any | drop_oh);
  assign drop_err = dropped && !ARESET;
endmodule

// File: tb/tb_b_resp_router.sv
// Directed bench for b_resp_router: a vector table covering single, stall,
// parallel and reset cases, plus sequences for contention and a 3-master build.

module tb_b_resp_router;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  src_empty;
  logic [9:0]  src_BID;
  logic [3:0]  src_BRESP;
  logic [1:0]  src_pop;
  logic [1:0]  BVALID;
  logic [1:0]  BREADY;
  logic [7:0]  BID;
  logic [3:0]  BRESP;
  logic        drop_err;

  // Three-master instance: 6-bit slave BID, dest index 3 is out of range
  logic [1:0]  e3, pop3;
  logic [11:0] bid3;
  logic [3:0]  bresp3;
  logic [2:0]  br3, bv3o;
  logic [11:0] id3o;
  logic [5:0]  rsp3o;
  logic        drop3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  b_resp_router u_dut (
    .ACLK(ACLK), .ARESET(ARESET), .src_empty(src_empty), .src_BID(src_BID),
    .src_BRESP(src_BRESP), .src_pop(src_pop), .BVALID(BVALID), .BREADY(BREADY),
    .BID(BID), .BRESP(BRESP), .drop_err(drop_err)
  );

  b_resp_router #(.NUM_SRC(2), .NUM_DST(3), .ID_WIDTH(4)) u_dut3 (
    .ACLK(ACLK), .ARESET(ARESET), .src_empty(e3), .src_BID(bid3),
    .src_BRESP(bresp3), .src_pop(pop3), .BVALID(bv3o), .BREADY(br3),
    .BID(id3o), .BRESP(rsp3o), .drop_err(drop3)
  );

  typedef struct {
    logic       rst;
    logic [1:0] empty;
    logic [9:0] bid;
    logic [3:0] bresp;
    logic [1:0] bready;
    logic [1:0] pop;    // expected in the drive cycle
    logic [1:0] vld;    // expected after the edge
    logic [7:0] id;
    logic [3:0] rsp;
  } vec_t;

  vec_t vt[18];

  function automatic logic [4:0] mk(input logic d, input logic [3:0] id);
    return {d, id};
  endfunction

  function automatic logic [5:0] mk3(input logic [1:0] d, input logic [3:0] id);
    return {d, id};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  logic [3:0] q0[$], q1[$];
  logic [1:0] pop_s, exp_pop;
  logic [7:0] idm;
  logic [3:0] rm;

  initial begin
    e3 = 2'b11; bid3 = '0; bresp3 = '0; br3 = '0;

    //            rst  empty   bid                          bresp    rdy    pop    vld    id     rsp
    vt[0]  = '{1'b1, 2'b10, {mk(0,0), mk(1,4'h5)},        4'b0000, 2'b00, 2'b00, 2'b00, 8'h00, 4'b0000};
    vt[1]  = '{1'b0, 2'b10, {mk(0,0), mk(1,4'h5)},        4'b0000, 2'b11, 2'b01, 2'b10, 8'h50, 4'b0000};
    vt[2]  = '{1'b0, 2'b11, 10'h0,                        4'b0000, 2'b11, 2'b00, 2'b00, 8'h00, 4'b0000};
    vt[3]  = '{1'b0, 2'b10, {mk(0,0), mk(0,4'h3)},        4'b0010, 2'b00, 2'b01, 2'b01, 8'h03, 4'b0010};
    for (int r = 4; r < 9; r++)
      vt[r] = '{1'b0, 2'b00, {mk(0,4'h9), mk(0,4'h7)},    4'b1101, 2'b00, 2'b00, 2'b01, 8'h03, 4'b0010};
    vt[9]  = '{1'b0, 2'b00, {mk(0,4'h9), mk(0,4'h7)},     4'b1101, 2'b01, 2'b10, 2'b01, 8'h09, 4'b0011};
    vt[10] = '{1'b0, 2'b10, {mk(0,0), mk(0,4'h7)},        4'b0001, 2'b01, 2'b01, 2'b01, 8'h07, 4'b0001};
    vt[11] = '{1'b0, 2'b11, 10'h0,                        4'b0000, 2'b01, 2'b00, 2'b00, 8'h00, 4'b0000};
    vt[12] = '{1'b0, 2'b00, {mk(1,4'hB), mk(0,4'hA)},     4'b1101, 2'b00, 2'b11, 2'b11, 8'hBA, 4'b1101};
    vt[13] = '{1'b0, 2'b11, 10'h0,                        4'b0000, 2'b11, 2'b00, 2'b00, 8'h00, 4'b0000};
    vt[14] = '{1'b0, 2'b01, {mk(1,4'h6), mk(0,0)},        4'b1000, 2'b00, 2'b10, 2'b10, 8'h60, 4'b1000};
    vt[15] = '{1'b1, 2'b00, {mk(0,4'h2), mk(0,4'h1)},     4'b0000, 2'b00, 2'b00, 2'b00, 8'h00, 4'b0000};
    vt[16] = '{1'b0, 2'b00, {mk(0,4'h2), mk(0,4'h1)},     4'b0000, 2'b01, 2'b01, 2'b01, 8'h01, 4'b0000};
    vt[17] = '{1'b0, 2'b11, 10'h0,                        4'b0000, 2'b11, 2'b00, 2'b00, 8'h00, 4'b0000};

    for (int r = 0; r < 18; r++) begin
      ARESET    = vt[r].rst;
      src_empty = vt[r].empty;
      src_BID   = vt[r].bid;
      src_BRESP = vt[r].bresp;
      BREADY    = vt[r].bready;
      #1;
      chk($sformatf("row%0d src_pop", r), 32'(src_pop), 32'(vt[r].pop));
      chk($sformatf("row%0d drop_err", r), 32'(drop_err), 32'd0);
      tick();
      idm = vt[r].rst ? 8'hFF : {{4{vt[r].vld[1]}}, {4{vt[r].vld[0]}}};
      rm  = vt[r].rst ? 4'hF  : {{2{vt[r].vld[1]}}, {2{vt[r].vld[0]}}};
      chk($sformatf("row%0d BVALID", r), 32'(BVALID), 32'(vt[r].vld));
      chk($sformatf("row%0d BID", r), 32'(BID & idm), 32'(vt[r].id & idm));
      chk($sformatf("row%0d BRESP", r), 32'(BRESP & rm), 32'(vt[r].rsp & rm));
    end

    // Contention: two sources, four entries each, all for master 0
    ARESET = 1'b1; src_empty = 2'b11; BREADY = 2'b00;
    tick();
    ARESET = 1'b0;
    q0 = '{4'h0, 4'h1, 4'h2, 4'h3};
    q1 = '{4'h8, 4'h9, 4'hA, 4'hB};
    for (int c = 0; c < 10; c++) begin
      src_empty = {q1.size() == 0, q0.size() == 0};
      src_BID   = {mk(0, (q1.size() > 0) ? q1[0] : 4'h0), mk(0, (q0.size() > 0) ? q0[0] : 4'h0)};
      src_BRESP = 4'b0100;
      BREADY    = 2'b01;
      #1;
      exp_pop = (c >= 8) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr c%0d src_pop", c), 32'(src_pop), 32'(exp_pop));
      pop_s = src_pop;
      tick();
      if (pop_s[0] && q0.size() > 0) void'(q0.pop_front());
      if (pop_s[1] && q1.size() > 0) void'(q1.pop_front());
      chk($sformatf("rr c%0d BVALID0", c), 32'(BVALID[0]), (c < 8) ? 32'd1 : 32'd0);
      if (c < 8) begin
        chk($sformatf("rr c%0d BID0", c), 32'(BID[3:0]), (c % 2 == 0) ? 32'(c / 2) : 32'(8 + c / 2));
        chk($sformatf("rr c%0d BRESP0", c), 32'(BRESP[1:0]), (c % 2 == 0) ? 32'd0 : 32'd1);
      end
    end
    src_empty = 2'b11;

    // Three masters: dest index 3 is discarded with drop_err
    br3 = 3'b111;
    e3 = 2'b10; bid3 = {mk3(2'd0, 4'h0), mk3(2'd3, 4'hC)};
    #1;
    chk("d3 single pop", 32'(pop3), 32'b01);
    chk("d3 single drop", 32'(drop3), 32'd1);
    tick();
    chk("d3 single bvalid", 32'(bv3o), 32'd0);
    e3 = 2'b11;
    #1;
    chk("d3 idle drop", 32'(drop3), 32'd0);
    chk("d3 idle pop", 32'(pop3), 32'd0);
    e3 = 2'b00; bid3 = {mk3(2'd3, 4'h1), mk3(2'd3, 4'h2)};
    #1;
    chk("d3 both pop first", 32'(pop3), 32'b01);
    chk("d3 both drop first", 32'(drop3), 32'd1);
    tick();
    e3 = 2'b01;
    #1;
    chk("d3 both pop second", 32'(pop3), 32'b10);
    chk("d3 both drop second", 32'(drop3), 32'd1);
    tick();
    chk("d3 both bvalid", 32'(bv3o), 32'd0);
    e3 = 2'b00; bid3 = {mk3(2'd3, 4'h4), mk3(2'd2, 4'hD)}; bresp3 = 4'b0011;
    #1;
    chk("d3 mix pop", 32'(pop3), 32'b11);
    chk("d3 mix drop", 32'(drop3), 32'd1);
    tick();
    chk("d3 mix bvalid", 32'(bv3o), 32'b100);
    chk("d3 mix bid", 32'(id3o[11:8]), 32'hD);
    chk("d3 mix bresp", 32'(rsp3o[5:4]), 32'd3);
    e3 = 2'b11;
    tick();
    chk("d3 final bvalid", 32'(bv3o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
